// File: rtl/depth_test_writer_if.sv
// Fragment stream handshake between a rasteriser and the depth-test writer.
interface depth_test_writer_if #(
  parameter int COLOR_WIDTH = 12,
  parameter int DEPTH_WIDTH = 16
);
  logic                   frag_valid;
  logic                   frag_ready;
  logic [15:0]            frag_x;
  logic [15:0]            frag_y;
  logic [DEPTH_WIDTH-1:0] frag_depth;
  logic [COLOR_WIDTH-1:0] frag_color;

  modport master (
    output frag_valid, frag_x, frag_y, frag_depth, frag_color,
    input  frag_ready
  );

  modport slave (
    input  frag_valid, frag_x, frag_y, frag_depth, frag_color,
    output frag_ready
  );
endinterface

// File: rtl/depth_test_writer.sv
// Two-stage z-test: read the stored depth on accept, compare and write colour/depth
// the following cycle, with frame clear sequencing and pass/fail statistics.
module depth_test_writer #(
  parameter int  SCREEN_WIDTH  = 160,
  parameter int  SCREEN_HEIGHT = 120,
  parameter int  COLOR_WIDTH   = 12,
  parameter int  DEPTH_WIDTH   = 16,
  localparam int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rstn,
  depth_test_writer_if.slave     frag,
  input  logic                   frame_clear,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  zb_addr_read,
  input  logic [DEPTH_WIDTH-1:0] zb_data_out,
  output logic [ADDR_WIDTH-1:0]  zb_addr_write,
  output logic [DEPTH_WIDTH-1:0] zb_data_in,
  output logic                   zb_write_enable,
  output logic [ADDR_WIDTH-1:0]  fb_addr_write,
  output logic [COLOR_WIDTH-1:0] fb_data_in,
  output logic                   fb_write_enable,
  output logic                   zb_clear,
  output logic                   fb_clear,
  input  logic                   zb_ready,
  input  logic                   fb_ready,
  output logic [15:0]            pass_count,
  output logic [15:0]            fail_count
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, WAIT} state_t;

  state_t                 state;
  logic                   clear_q;
  logic                   accept;
  logic                   in_range;

  logic                   s1_valid;
  logic                   s1_in_range;
  logic [ADDR_WIDTH-1:0]  s1_addr;
  logic [DEPTH_WIDTH-1:0] s1_depth;
  logic [COLOR_WIDTH-1:0] s1_color;

  logic                   fwd_valid;
  logic [ADDR_WIDTH-1:0]  fwd_addr;
  logic [DEPTH_WIDTH-1:0] fwd_depth;

  logic [DEPTH_WIDTH-1:0] ref_depth;
  logic                   active;
  logic                   closer;
  logic                   depth_pass;
  logic                   depth_fail;

  assign frag.frag_ready = (state == RUN) && !frame_clear && zb_ready && fb_ready;
  assign accept          = frag.frag_valid && frag.frag_ready;
  assign in_range        = (32'(frag.frag_x) < SCREEN_WIDTH) && (32'(frag.frag_y) < SCREEN_HEIGHT);
  assign zb_addr_read    = ADDR_WIDTH'(32'(frag.frag_y) * SCREEN_WIDTH + 32'(frag.frag_x));

  // The memory has not yet absorbed last cycle's write, so compare against it directly.
  assign ref_depth  = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_depth : zb_data_out;
  assign active     = rstn && ((state == RUN) || (state == DRAIN));
  assign closer     = s1_depth < ref_depth;
  assign depth_pass = active && s1_valid && s1_in_range && closer;
  assign depth_fail = active && s1_valid && s1_in_range && !closer;

  assign zb_write_enable = depth_pass;
  assign zb_addr_write   = s1_addr;
  assign zb_data_in      = s1_depth;
  assign fb_write_enable = depth_pass;
  assign fb_addr_write   = s1_addr;
  assign fb_data_in      = s1_color;

  assign zb_clear = clear_q;
  assign fb_clear = clear_q;
  assign busy     = rstn && ((state != RUN) || s1_valid);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= RUN;
      clear_q    <= 1'b0;
      s1_valid   <= 1'b0;
      fwd_valid  <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_in_range <= in_range;
        s1_addr     <= zb_addr_read;
        s1_depth    <= frag.frag_depth;
        s1_color    <= frag.frag_color;
      end

      fwd_valid <= depth_pass;
      if (depth_pass) begin
        fwd_addr  <= s1_addr;
        fwd_depth <= s1_depth;
      end

      if (depth_pass && (pass_count != 16'hFFFF)) pass_count <= pass_count + 16'd1;
      if (depth_fail && (fail_count != 16'hFFFF)) fail_count <= fail_count + 16'd1;

      clear_q <= 1'b0;
      // Counter zeroing on CLEAR entry overrides any increment above.
      case (state)
        RUN: begin
          if (frame_clear) begin
            if (s1_valid) begin
              state <= DRAIN;
            end else begin
              state      <= CLEAR;
              clear_q    <= 1'b1;
              pass_count <= '0;
              fail_count <= '0;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state      <= CLEAR;
            clear_q    <= 1'b1;
            pass_count <= '0;
            fail_count <= '0;
          end
        end
        CLEAR: state <= WAIT;
        WAIT: begin
          if (zb_ready && fb_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
